firebird_dmem_resp: RTL

- Data-memory responder for the firebird core; the other end of the decoder's mem_read/mem_write control lines.
- Accepts one load or store request, waits a configurable latency, performs the access on an internal word-organised RAM, then pulses ready.
- RISC-V byte, half and word accesses are supported, with load sign/zero extension and misalignment detection.
- Sits between the datapath (address from the ALU result, store data from rs2) and the write-back mux selected by mem_to_reg.

---
 rtl/firebird_dmem_resp.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/firebird_dmem_resp.sv
// firebird data-memory responder: one load/store in flight, fixed access
// latency, word RAM with byte enables, RISC-V size/sign handling and
// misalignment / bad-funct3 / double-request error reporting.
module firebird_dmem_resp #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  // Upper address bits wrap around and are intentionally dropped.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  assign widx    = addr_q[AW+1:2];
  assign lane    = addr_q[1:0];
  assign rd_word = mem[widx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  logic          acc_err;
  logic [31:0]   ld_val;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic          mem_we;

  // Access decode: alignment/funct3 check, load extension, store lane enables.
  // Store data is replicated across lanes so the byte enables alone place it.
  always_comb begin
    acc_err = 1'b0;
    ld_val  = rd_word;
    st_data = wdata_q;
    st_be   = 4'b0000;
    if (!wr_q) begin
      case (f3_q)
        3'b000: ld_val = {{24{rd_byte[7]}}, rd_byte};
        3'b100: ld_val = {24'b0, rd_byte};
        3'b001: begin
          acc_err = lane[0];
          ld_val  = {{16{rd_half[15]}}, rd_half};
        end
        3'b101: begin
          acc_err = lane[0];
          ld_val  = {16'b0, rd_half};
        end
        3'b010:  acc_err = |lane;
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (f3_q)
        3'b000: begin
          st_be   = 4'b0001 << lane;
          st_data = {4{wdata_q[7:0]}};
        end
        3'b001: begin
          acc_err = lane[0];
          st_be   = lane[1] ? 4'b1100 : 4'b0011;
          st_data = {2{wdata_q[15:0]}};
        end
        3'b010: begin
          acc_err = |lane;
          st_be   = 4'b1111;
        end
        default: acc_err = 1'b1;
      endcase
    end
  end

  // Next-state: accept in IDLE, count down in BUSY, access on the last BUSY edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read && mem_write) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_read || mem_write) begin
          wr_d    = mem_write;
          addr_d  = addr[AW+1:0];
          f3_d    = funct3;
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = acc_err;
          if (!acc_err && !wr_q) rdata_d = ld_val;
          // A reset on this edge aborts the access.
          mem_we  = wr_q && !acc_err && !rst;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-enabled RAM write; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[widx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    ready = (state_q == RESP);
    busy  = (state_q == BUSY);
    rdata = rdata_q;
    err   = err_q;
  end

endmodule
